// File: rtl/router_arb_pkg.sv
// Shared types for the router output-port arbiter.
// Port indices, flit type and pointer width.
package router_arb_pkg;

  localparam int NUM_PORTS = 5;
  localparam int FLIT_W    = 10;
  localparam int PTR_W     = 3;

  typedef enum logic [PTR_W-1:0] {
    P_W  = 3'd0,
    P_E  = 3'd1,
    P_N  = 3'd2,
    P_S  = 3'd3,
    P_PE = 3'd4
  } port_e;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/router_out_arb_rr_pick.sv
// Round-robin pick: rotate req by ptr, take lowest set bit, rotate back.
// Ports: req, ptr in; one-hot gnt, idx and any out.
module rr_pick
  import router_arb_pkg::*;
#(
  parameter int N = NUM_PORTS
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]     rot;
  logic [PTR_W-1:0] enc;
  logic [PTR_W:0]   sum;

  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      rot[k] = req[j];
    end
  end

  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) enc = PTR_W'(i);
    end
  end

  assign any = |rot;
  assign sum = {1'b0, ptr} + {1'b0, enc};
  assign idx = (sum >= (PTR_W+1)'(N)) ?
               PTR_W'(sum - (PTR_W+1)'(N)) :
               sum[PTR_W-1:0];
  assign gnt = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/router_out_arb.sv
// Credit-gated round-robin arbiter with 1-entry output register.
// Ports: req_valid/req_data/req_ready, out_*, credit_ret, credits,
// grant_idx; ROUTER_ARB_STATS_EN adds grant_cnt and stall_cyc.
module router_out_arb
  import router_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_PORTS,
  parameter int WIDTH   = FLIT_W,
  parameter int CREDITS = 4,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  input  logic                     credit_ret,
  output logic [CNT_W-1:0]         credits,
  output logic [PTR_W-1:0]         grant_idx
`ifdef ROUTER_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    grant_cnt,
  output logic [15:0]              stall_cyc
`endif
);

  localparam logic [CNT_W-1:0] CMAX = CNT_W'(CREDITS);

  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   win;
  logic               any;
  logic               can_accept;
  logic               accept;
  logic [WIDTH-1:0]   win_data;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  // Only the registered count gates; a same-cycle credit_ret waits.
  assign can_accept = (credits != '0) && (!out_valid || out_ready);
  assign req_ready  = (can_accept && any) ? gnt : '0;
  assign accept     = can_accept && any;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) win_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      grant_idx <= win;
      rr_ptr    <= (win == PTR_W'(NUM_REQ - 1)) ?
                   '0 : win + PTR_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= CMAX;
    end else if (accept && !credit_ret) begin
      credits <= credits - CNT_W'(1);
    end else if (credit_ret && !accept && credits != CMAX) begin
      credits <= credits + CNT_W'(1);
    end
  end

  // Returning a credit that was never taken is a downstream bug.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(credit_ret && !accept && credits == CMAX));
    end
  end

`ifdef ROUTER_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cyc <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && gnt[i] &&
            grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
      if ((|req_valid) && !accept && stall_cyc != 16'hFFFF)
        stall_cyc <= stall_cyc + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_out_arb.sv
// Self-checking bench for router_out_arb against a queue-free
// behavioural model of the arbitration and credit rules.
module tb_router_out_arb;

  localparam int N = 5;
  localparam int W = 10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic           credit_ret;
  logic [2:0]     credits;
  logic [2:0]     grant_idx;
`ifdef ROUTER_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     stall_cyc;
`endif

  router_out_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .credit_ret (credit_ret),
    .credits    (credits),
    .grant_idx  (grant_idx)
`ifdef ROUTER_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt),
    .stall_cyc  (stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] flits [N];

  int         m_ptr;
  int         m_cred;
  bit         m_ov;
  logic [W-1:0] m_od;
  int         m_gi;
  int         m_gcnt [N];
  int         m_stall;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cred = 4; m_ov = 0; m_od = '0; m_gi = 0;
    m_stall = 0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = flits[i];
  endtask

  // One clock: check req_ready, clock, update model, check outputs.
  task automatic step(output int won);
    logic [N-1:0] er;
    int w;
    bit can, acc;
    pack();
    #1;
    can = (m_cred != 0) && (!m_ov || out_ready);
    w = pick(req_valid, m_ptr);
    er = (can && w >= 0) ? N'(1 << w) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    acc = (er != 0);
    won = acc ? w : -1;
    @(posedge clk);
    if (acc) begin
      m_od = flits[w]; m_ov = 1; m_gi = w;
      m_ptr = (w + 1) % N;
      if (m_gcnt[w] < 16'hFFFF) m_gcnt[w]++;
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
    if (req_valid != 0 && !acc && m_stall < 16'hFFFF) m_stall++;
    m_cred = m_cred - int'(acc) + int'(credit_ret);
    if (m_cred > 4) m_cred = 4;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("grant_idx", 32'(grant_idx), 32'(m_gi));
    chk("credits", 32'(credits), 32'(m_cred));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; credit_ret = 0; out_ready = 1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_credits", 32'(credits), 32'd4);
`ifdef ROUTER_ARB_STATS_EN
    chk("rst_grant_cnt", 32'(grant_cnt == '0), 32'd1);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int won;
    int exp_w;
    logic [W-1:0] held;
    for (int i = 0; i < N; i++) flits[i] = W'(i * 7 + 1);
    req_data = '0;
    @(negedge clk);

    // Reset
    do_reset();
    chk("idle_ready", 32'(req_ready), 32'd0);
    chk("idle_out_data", 32'(out_data), 32'd0);

    // Single requester N
    flits[2] = 10'h155;
    req_valid = 5'b00100;
    step(won);
    chk("single_win", 32'(won), 32'd2);
    chk("single_cred", 32'(credits), 32'd3);
    req_valid = '0;
    step(won);

    // Round robin with constant credit
    req_valid = 5'b11111;
    credit_ret = 1;
    exp_w = m_ptr;
    for (int c = 0; c < 6; c++) begin
      flits[exp_w] = W'($urandom);
      step(won);
      chk("rr_order", 32'(won), 32'(exp_w));
      chk("rr_cred", 32'(credits), 32'd3);
      exp_w = (exp_w + 1) % N;
    end

    // Credit exhaustion
    credit_ret = 0;
    repeat (3) step(won);
    chk("exh_cred", 32'(credits), 32'd0);
    step(won);
    chk("exh_none", 32'(won), 32'hFFFFFFFF);
    credit_ret = 1;
    step(won);
    chk("exh_same_cycle", 32'(won), 32'hFFFFFFFF);
    credit_ret = 0;
    step(won);
    chk("exh_one_acc", 32'(won >= 0), 32'd1);
    chk("exh_cred0", 32'(credits), 32'd0);
    step(won);
    chk("exh_none2", 32'(won), 32'hFFFFFFFF);

    // Backpressure
    do_reset();
    flits[1] = 10'h2AA;
    req_valid = 5'b00010;
    step(won);
    held = out_data;
    chk("bp_flit", 32'(held), 32'h2AA);
    req_valid = 5'b11101;
    out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      step(won);
      chk("bp_stable", 32'(out_data), 32'h2AA);
      chk("bp_cred", 32'(credits), 32'd3);
    end
    out_ready = 1;
    step(won);
    chk("bp_release", 32'(won), 32'd2);

    // Reset mid-transfer
    do_reset();
    req_valid = 5'b11111;
    repeat (3) step(won);
    chk("mid_ov", 32'(out_valid), 32'd1);
    chk("mid_cred", 32'(credits), 32'd1);
    do_reset();

    // Random traffic with well-behaved downstream
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          flits[i] = W'($urandom);
        end
      end
      out_ready  = ($urandom_range(0, 3) != 0);
      credit_ret = (m_cred < 4) && ($urandom_range(0, 1) == 1);
      step(won);
      if (won >= 0) req_valid[won] = 1'b0;
    end
    req_valid = '0; credit_ret = 0;

`ifdef ROUTER_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'(m_gcnt[i]));
    chk("stall_cyc", 32'(stall_cyc), 32'(m_stall));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
